itrx_apb4_slave_regs: RTL
=========================

ITRX_APB4_SLAVE_REGS -- requirements
Module: itrx_apb4_slave_regs

Interface
REQ-001 The block SHALL have parameter PDATAW, default 32, meaning data width in bits; legal values 8, 16, 32, 64.
REQ-002 The block SHALL have parameter NREGS, default 16, meaning number of registers; legal values 1..256.
REQ-003 The block SHALL have parameter WAITS, default 0, meaning wait states inserted per transfer; legal values 0..15.
REQ-004 The block SHALL have parameter BASE, default 32'h0, meaning byte address of register 0; aligned to PDATAW/8.
REQ-005 The block SHALL have parameter RST_VAL, default all-zero, meaning reset value of every register.
REQ-006 The block SHALL have port pclk, input, 1 bit: the single clock; all state is rising-edge.
REQ-007 The block SHALL have port preset, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have ports paddr (input, 32, byte address), pwrite (input, 1, te_pwrite), pwdata (input, PDATAW), pstrb (input, PDATAW/8, byte lanes), pprot (input, 3), psel (input, 1) and penable (input, 1).
REQ-009 The block SHALL have ports prdata (output, PDATAW), pready (output, 1) and pslverr (output, 1).
REQ-010 The block SHALL have ports reg_q (output, NREGS*PDATAW, register contents, register i in bits [i*PDATAW +: PDATAW]) and wr_pulse (output, NREGS, one-cycle pulse per committed write).

Function
REQ-011 FSM SHALL have states IDLE, ACCESS and WAIT.
REQ-012 IDLE -> ACCESS when psel=1 and penable=0; the wait counter loads WAITS on that edge.
REQ-013 In ACCESS with counter != 0, pready=0 and the counter decrements each cycle.
REQ-014 In ACCESS with counter == 0, pready=1 (combinational) and the transfer completes.
REQ-015 On completion the FSM SHALL go to IDLE, or to ACCESS with the counter reloaded if psel=1 and penable=0 in that same cycle (back-to-back).
REQ-016 psel=0 in ACCESS SHALL abort the transfer to IDLE with no write and no wr_pulse.
REQ-017 WAIT is unused when WAITS=0; when WAITS>0 it is entered only by aliasing, i.e. ACCESS is the counting state; WAIT SHALL fall through to IDLE (defensive).
REQ-018 Index SHALL be (paddr-BASE)>>log2(PDATAW/8), computed modulo 2^32.
REQ-019 Error SHALL be flagged when any of the following holds: low address bits nonzero; index >= NREGS; paddr < BASE; pwrite=WRITE with pprot[0]=0 (unprivileged write).
REQ-020 pslverr SHALL equal the error flag when pready=1, and be 0 otherwise.
REQ-021 A write SHALL commit on the completion cycle when pwrite=WRITE and there is no error; only bytes with pstrb[b]=1 are updated.
REQ-022 wr_pulse[index] SHALL be 1 the cycle after commit; a write with pstrb all-zero still pulses.
REQ-023 On read completion without error, prdata SHALL be the register value; prdata SHALL be 0 on error and whenever pready=0.
REQ-024 Reads SHALL ignore pstrb; unprivileged reads are permitted.
REQ-025 Transfer latency SHALL be 2+WAITS cycles from the setup cycle to completion, inclusive.

Reset
REQ-026 preset=1 SHALL immediately force IDLE, counter=0, all registers=RST_VAL, wr_pulse=0, pready=0, pslverr=0 and prdata=0.
REQ-027 Reset mid-transfer SHALL discard the transfer; after release the FSM waits for a new setup phase.

Structure
REQ-028 Package itrx_amba4_apb_pkg SHALL hold te_pwrite (READ=0, WRITE=1), te_apb_state and the PPROT bit-position constants.
REQ-029 Wait-state counter sub-module itrx_apb_wait_cnt SHALL provide load, decrement and zero flag, with width $clog2(WAITS+1) and a minimum of 1.

Verification
REQ-030 Reset, WAITS=0: read at BASE+0 -> pready=1 on 2nd cycle, prdata=RST_VAL, pslverr=0.
REQ-031 WAITS=3: write 32'hDEADBEEF, pstrb=4'b0101, pprot=3'b001, addr BASE+8 -> pready low 3 ACCESS cycles then high; reg2=32'h00AD00EF; wr_pulse[2] one cycle.
REQ-032 Write to BASE+4*NREGS, then misaligned BASE+2 -> pslverr=1 on completion, reg_q unchanged, no wr_pulse.
REQ-033 Unprivileged write (pprot=3'b000) to reg1 -> pslverr=1 and no change; an unprivileged read of reg1 -> pslverr=0.
REQ-034 Back-to-back write reg0 then read reg0 with no IDLE gap -> read returns the new value, 4 cycles total at WAITS=0.
REQ-035 preset asserted during an ACCESS wait, and psel dropped mid-ACCESS -> no commit, FSM in IDLE, next transfer behaves normally.

Source files
------------

// File: rtl/itrx_amba4_apb_pkg.sv
// Shared APB4 types and constants for the register slave and its wait-state counter.
package itrx_amba4_apb_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } te_pwrite;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } te_apb_state;

    localparam int PPROT_PRIV  = 0;
    localparam int PPROT_NSEC  = 1;
    localparam int PPROT_INSTR = 2;

    // Counter width able to hold WAITS, never narrower than one bit.
    function automatic int wait_cnt_width(input int waits);
        return (waits > 0) ? $clog2(waits + 1) : 1;
    endfunction

endpackage

// File: rtl/itrx_apb_wait_cnt.sv
// Wait-state down-counter: load with WAITS at setup, count down while the slave stalls.
module itrx_apb_wait_cnt
    import itrx_amba4_apb_pkg::*;
#(
    parameter int WAITS = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);
    localparam int            CW       = wait_cnt_width(WAITS);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAITS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/itrx_apb4_slave_regs.sv
// APB4 slave exposing NREGS byte-strobed registers with optional wait states and
// privileged-write protection; every register is also visible on reg_q.
module itrx_apb4_slave_regs
    import itrx_amba4_apb_pkg::*;
#(
    parameter int                PDATAW  = 32,
    parameter int                NREGS   = 16,
    parameter int                WAITS   = 0,
    parameter logic [31:0]       BASE    = 32'h0,
    parameter logic [PDATAW-1:0] RST_VAL = '0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [31:0]             paddr,
    input  te_pwrite                pwrite,
    input  logic [PDATAW-1:0]       pwdata,
    input  logic [PDATAW/8-1:0]     pstrb,
    input  logic [2:0]              pprot,
    input  logic                    psel,
    input  logic                    penable,
    output logic [PDATAW-1:0]       prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [NREGS*PDATAW-1:0] reg_q,
    output logic [NREGS-1:0]        wr_pulse
);
    localparam int          NB    = PDATAW / 8;
    localparam int          AL    = $clog2(NB);
    localparam logic [31:0] AMASK = 32'(NB - 1);

    te_apb_state       state_q;
    te_apb_state       state_d;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              complete;
    logic              acc_err;
    logic              commit;
    logic              rd_hit;
    logic [31:0]       offs;
    logic [31:0]       idx;
    logic [PDATAW-1:0] rd_mux;
    logic [NREGS-1:0]  wr_pulse_q;
    logic [NREGS-1:0]  wr_pulse_d;
    logic              unused_pprot;

    assign unused_pprot = &{1'b0, pprot[PPROT_INSTR], pprot[PPROT_NSEC]};

    // Address decode wraps modulo 2^32; addresses below BASE are caught explicitly.
    assign offs    = paddr - BASE;
    assign idx     = offs >> AL;
    assign acc_err = ((paddr & AMASK) != '0)
                  || (idx >= 32'(NREGS))
                  || (paddr < BASE)
                  || ((pwrite == WRITE) && !pprot[PPROT_PRIV]);

    itrx_apb_wait_cnt #(
        .WAITS (WAITS)
    ) u_wait_cnt (
        .clk_i  (pclk),
        .rst_i  (preset),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        pready   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    cnt_load = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    pready   = 1'b1;
                    complete = 1'b1;
                    if (penable) begin
                        state_d = IDLE;
                    end else begin
                        cnt_load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pslverr = pready & acc_err;
    assign commit  = complete && (pwrite == WRITE) && !acc_err;
    assign rd_hit  = complete && (pwrite == READ) && !acc_err;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == 32'(i)) begin
                rd_mux = reg_q[i*PDATAW +: PDATAW];
            end
        end
    end

    assign prdata = rd_hit ? rd_mux : '0;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic              hit;
        logic [PDATAW-1:0] data_q;
        logic [PDATAW-1:0] data_d;

        assign hit            = commit && (idx == 32'(gi));
        assign wr_pulse_d[gi] = hit;

        always_comb begin
            data_d = data_q;
            for (int b = 0; b < NB; b++) begin
                if (hit && pstrb[b]) begin
                    data_d[b*8 +: 8] = pwdata[b*8 +: 8];
                end
            end
        end

        always_ff @(posedge pclk or posedge preset) begin
            if (preset) begin
                data_q <= RST_VAL;
            end else begin
                data_q <= data_d;
            end
        end

        assign reg_q[gi*PDATAW +: PDATAW] = data_q;
    end

    // A strobe-less write still commits, so the pulse follows commit, not data change.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign wr_pulse = wr_pulse_q;

endmodule
